// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops A_SIZE-bit entries from a FIFO read port and packs
// PACK of them (first entry in the LSBs) into one output word. A flush pulse
// emits a partially filled word, with the unused slots left at zero.
module fifo_rd_packer #(
  parameter int unsigned A_SIZE = 8,
  parameter int unsigned PACK   = 4
) (
  input  logic                        r_clk,
  input  logic                        rrst,
  input  logic                        r_empty,
  output logic                        r_enable,
  input  logic [A_SIZE-1:0]           r_data,
  input  logic                        flush,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [A_SIZE*PACK-1:0]      o_data,
  output logic [$clog2(PACK):0]       o_bytes,
  output logic [15:0]                 o_word_cnt
);

  localparam int unsigned DW = A_SIZE * PACK;
  localparam int unsigned CW = $clog2(PACK) + 1;
  localparam logic [CW:0] PACK_E = (CW+1)'(PACK);

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            inflight_q;
  logic            flush_pend_q;
  logic            o_valid_q;
  logic [DW-1:0]   o_data_q;
  logic [CW-1:0]   o_bytes_q;
  logic [15:0]     word_cnt_q;

  logic [CW:0]     cnt_land_d;
  logic            fl_req_c;
  logic            completes_now_c;
  logic            flush_pend_d;

  // Entry count once the in-flight entry (if any) has landed this edge
  assign cnt_land_d = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};

  // Pop only while filling, with room for every requested entry, and never
  // once a flush is waiting for the in-flight entry to land
  assign r_enable = !rrst && (state_q == FILL) && !r_empty &&
                    (cnt_land_d < PACK_E) && !flush_pend_q;

  // Flush is meaningful only in FILL with at least one entry held or in flight
  assign fl_req_c = flush && (state_q == FILL) && ((cnt_q != '0) || inflight_q);

  // A flush alongside the pop that completes the word yields the full word
  assign completes_now_c = r_enable && ((cnt_land_d + (CW+1)'(1)) == PACK_E);

  assign flush_pend_d = flush_pend_q || (fl_req_c && !completes_now_c);

  // Packing FSM, capture datapath and accepted-word counter
  always_ff @(posedge r_clk) begin
    if (rrst) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      o_valid_q    <= 1'b0;
      o_data_q     <= '0;
      o_bytes_q    <= '0;
      word_cnt_q   <= '0;
    end else begin
      case (state_q)
        FILL: begin
          inflight_q <= r_enable;
          if (inflight_q) begin
            o_data_q[A_SIZE*int'(cnt_q) +: A_SIZE] <= r_data;
          end
          cnt_q <= cnt_land_d[CW-1:0];
          if (cnt_land_d == PACK_E) begin
            state_q      <= OUT;
            o_valid_q    <= 1'b1;
            o_bytes_q    <= cnt_land_d[CW-1:0];
            flush_pend_q <= 1'b0;
          end else if (flush_pend_d && !r_enable && (cnt_land_d != '0)) begin
            state_q      <= OUT;
            o_valid_q    <= 1'b1;
            o_bytes_q    <= cnt_land_d[CW-1:0];
            flush_pend_q <= 1'b0;
          end else begin
            flush_pend_q <= flush_pend_d;
          end
        end
        OUT: begin
          inflight_q <= 1'b0;
          if (o_ready) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_bytes_q  <= '0;
            word_cnt_q <= word_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  assign o_valid    = o_valid_q;
  assign o_data     = o_data_q;
  assign o_bytes    = o_bytes_q;
  assign o_word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (A_SIZE=8, PACK=4) with a simple FIFO model.
module tb_fifo_rd_packer;

  localparam int unsigned A_SIZE = 8;
  localparam int unsigned PACK   = 4;

  logic        r_clk = 1'b0;
  logic        rrst;
  logic        r_empty;
  logic        r_enable;
  logic [7:0]  r_data = '0;
  logic        flush;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_data;
  logic [2:0]  o_bytes;
  logic [15:0] o_word_cnt;

  logic [7:0]  mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  int          ncheck = 0;
  int          nfail  = 0;
  int          n;

  always #5 r_clk = ~r_clk;

  fifo_rd_packer #(.A_SIZE(A_SIZE), .PACK(PACK)) dut (
    .r_clk      (r_clk),
    .rrst       (rrst),
    .r_empty    (r_empty),
    .r_enable   (r_enable),
    .r_data     (r_data),
    .flush      (flush),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_bytes    (o_bytes),
    .o_word_cnt (o_word_cnt)
  );

  // FIFO model: data appears the cycle after a sampled pop
  assign r_empty = (rd_ptr == wr_ptr);

  always @(posedge r_clk) begin
    if (r_enable) begin
      r_data <= mem[rd_ptr[9:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] v);
    mem[wr_ptr[9:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncheck++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance negedge by negedge until o_valid, bounded by max cycles
  task automatic wait_valid(input int max, output int cycles);
    cycles = 0;
    do begin
      @(negedge r_clk);
      cycles++;
    end while (o_valid !== 1'b1 && cycles < max);
  endtask

  initial begin
    rrst    = 1'b1;
    flush   = 1'b0;
    o_ready = 1'b1;
    repeat (2) @(negedge r_clk);

    // Reset state with a non-empty FIFO
    for (int i = 0; i < 4; i++) push(8'(i));
    @(negedge r_clk);
    chk("rst_r_enable", r_enable, 1'b0);
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_o_data", o_data, 32'h0);
    chk("rst_o_bytes", o_bytes, 3'd0);
    chk("rst_word_cnt", o_word_cnt, 16'd0);

    // Basic word 0x00..0x03 and latency from first pop
    rrst = 1'b0;
    #1;
    chk("first_r_enable", r_enable, 1'b1);
    wait_valid(20, n);
    chk("basic_latency", n, 5);
    chk("basic_o_data", o_data, 32'h03020100);
    chk("basic_o_bytes", o_bytes, 3'd4);
    @(negedge r_clk);
    chk("basic_word_cnt", o_word_cnt, 16'd1);
    chk("basic_valid_clr", o_valid, 1'b0);
    chk("basic_data_clr", o_data, 32'h0);

    // Backpressure: word held for 10 cycles with more entries waiting
    o_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    wait_valid(20, n);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall_data_%0d", i), o_data, 32'h13121110);
      chk($sformatf("stall_ren_%0d", i), r_enable, 1'b0);
      chk($sformatf("stall_valid_%0d", i), o_valid, 1'b1);
      @(negedge r_clk);
    end
    o_ready = 1'b1;
    @(negedge r_clk);
    chk("stall_accept_cnt", o_word_cnt, 16'd2);
    chk("stall_accept_valid", o_valid, 1'b0);
    wait_valid(20, n);
    chk("stall_next_data", o_data, 32'h17161514);
    @(negedge r_clk);
    chk("stall_next_cnt", o_word_cnt, 16'd3);

    // Flush coinciding with the word-completing pop is ignored
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    repeat (3) @(negedge r_clk);
    flush = 1'b1;
    @(negedge r_clk);
    flush = 1'b0;
    @(negedge r_clk);
    chk("fl_last_valid", o_valid, 1'b1);
    chk("fl_last_bytes", o_bytes, 3'd4);
    chk("fl_last_data", o_data, 32'h44434241);
    @(negedge r_clk);
    chk("fl_last_cnt", o_word_cnt, 16'd4);

    // Partial word via flush with FIFO empty, then flush with nothing held
    push(8'hAA); push(8'hBB);
    repeat (4) @(negedge r_clk);
    chk("partial_no_emit", o_valid, 1'b0);
    flush = 1'b1;
    @(negedge r_clk);
    flush = 1'b0;
    chk("partial_valid", o_valid, 1'b1);
    chk("partial_data", o_data, 32'h0000BBAA);
    chk("partial_bytes", o_bytes, 3'd2);
    @(negedge r_clk);
    chk("partial_cnt", o_word_cnt, 16'd5);
    flush = 1'b1;
    @(negedge r_clk);
    flush = 1'b0;
    repeat (2) @(negedge r_clk);
    chk("empty_flush_valid", o_valid, 1'b0);
    chk("empty_flush_cnt", o_word_cnt, 16'd5);

    // Flush while the third entry is in flight
    push(8'hAA); push(8'hBB);
    repeat (4) @(negedge r_clk);
    push(8'hCC);
    @(negedge r_clk);
    flush = 1'b1;
    @(negedge r_clk);
    flush = 1'b0;
    chk("inflight_valid", o_valid, 1'b1);
    chk("inflight_data", o_data, 32'h00CCBBAA);
    chk("inflight_bytes", o_bytes, 3'd3);
    @(negedge r_clk);
    chk("inflight_cnt", o_word_cnt, 16'd6);

    // Reset mid-word discards held entries
    push(8'h51); push(8'h52);
    repeat (4) @(negedge r_clk);
    rrst = 1'b1;
    @(negedge r_clk);
    push(8'h61); push(8'h62); push(8'h63); push(8'h64);
    #1;
    chk("midrst_r_enable", r_enable, 1'b0);
    chk("midrst_valid", o_valid, 1'b0);
    chk("midrst_data", o_data, 32'h0);
    chk("midrst_bytes", o_bytes, 3'd0);
    chk("midrst_cnt", o_word_cnt, 16'd0);
    @(negedge r_clk);
    rrst = 1'b0;
    wait_valid(20, n);
    chk("midrst_word_data", o_data, 32'h64636261);
    chk("midrst_word_bytes", o_bytes, 3'd4);
    @(negedge r_clk);
    chk("midrst_word_cnt", o_word_cnt, 16'd1);

    // Streaming 256 entries into 64 words
    rrst = 1'b1;
    @(negedge r_clk);
    rrst = 1'b0;
    for (int i = 0; i < 256; i++) push(8'(i));
    for (int k = 0; k < 64; k++) begin
      logic [31:0] exp_w;
      exp_w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      wait_valid(20, n);
      chk($sformatf("stream_word_%0d", k), o_data, exp_w);
    end
    @(negedge r_clk);
    chk("stream_word_cnt", o_word_cnt, 16'd64);
    chk("stream_drained", rd_ptr, wr_ptr);
    chk("stream_idle_valid", o_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
    $finish;
  end

endmodule
